beta_regfile: RTL and testbench

Register file at the receiving end of the write-back interface in the Beta pipeline. The WB stage drives `rf_w_en`, `rf_w_addr` and `rf_w_data` into this block. It serves three combinational read ports (Ra, Rb, Rc) to the RF/decode stage, with same-cycle write-to-read bypass. R31 is hardwired to zero. After reset, a sequential clear engine zeroes R0–R30, and the pipeline is stalled until `rf_ready` asserts.

---
 rtl/beta_regfile.sv | 93 +++++++++
 tb/tb_beta_regfile.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/beta_regfile.sv
// Beta register file: 31 x 32-bit storage (R0-R30), R31 reads as zero.
// Three combinational read ports with optional same-cycle write bypass.
// After reset a sequential engine zeroes R0-R30 one per cycle before rf_ready rises.
module beta_regfile #(
  parameter bit BYPASS         = 1'b1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rf_w_en,
  input  logic [4:0]  rf_w_addr,
  input  logic [31:0] rf_w_data,
  input  logic [4:0]  ra_addr,
  output logic [31:0] ra_data,
  input  logic [4:0]  rb_addr,
  output logic [31:0] rb_data,
  input  logic [4:0]  rc_addr,
  output logic [31:0] rc_data,
  output logic        rf_ready
);

  localparam logic [4:0] ZeroReg = 5'd31;
  localparam logic [4:0] LastReg = 5'd30;

  typedef enum logic {StClear, StReady} state_e;

  state_e      state_q;
  logic [4:0]  clr_cnt_q;
  logic        rf_ready_q;
  logic [31:0] regs [0:30];

  logic clear_wr;
  logic port_wr;

  assign clear_wr = CLEAR_ON_RESET && (state_q == StClear);
  assign port_wr  = (state_q == StReady) && rf_w_en && (rf_w_addr != ZeroReg);

  // Clear/ready FSM; clr_cnt holds at 30 once the last register is cleared.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StClear;
      clr_cnt_q  <= '0;
      rf_ready_q <= 1'b0;
    end else if (state_q == StClear) begin
      if (!CLEAR_ON_RESET || (clr_cnt_q == LastReg)) begin
        state_q    <= StReady;
        rf_ready_q <= 1'b1;
      end else begin
        clr_cnt_q <= clr_cnt_q + 5'd1;
      end
    end
  end

  // Storage update: clear engine owns the array in CLEAR, WB writes only in READY.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (clear_wr) begin
        regs[clr_cnt_q] <= '0;
      end else if (port_wr) begin
        regs[rf_w_addr] <= rf_w_data;
      end
    end
  end

  // Shared read rule: CLEAR and R31 read zero, then bypass, then storage.
  function automatic logic [31:0] read_port(input state_e      st,
                                            input logic [4:0]  addr,
                                            input logic        w_en,
                                            input logic [4:0]  w_addr,
                                            input logic [31:0] w_data,
                                            input logic [31:0] stored);
    logic [31:0] val;
    val = stored;
    if (st == StClear) begin
      val = '0;
    end else if (addr == ZeroReg) begin
      val = '0;
    end else if (BYPASS && w_en && (w_addr == addr)) begin
      val = w_data;
    end
    return val;
  endfunction

  // Combinational read ports.
  always_comb begin
    ra_data = read_port(state_q, ra_addr, rf_w_en, rf_w_addr, rf_w_data, regs[ra_addr]);
    rb_data = read_port(state_q, rb_addr, rf_w_en, rf_w_addr, rf_w_data, regs[rb_addr]);
    rc_data = read_port(state_q, rc_addr, rf_w_en, rf_w_addr, rf_w_data, regs[rc_addr]);
  end

  assign rf_ready = rf_ready_q;

endmodule

// File: tb/tb_beta_regfile.sv
// Directed bench for beta_regfile: bypassing, non-bypassing and no-clear instances
// share one stimulus stream; expected values are hand-computed constants.
module tb_beta_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rf_w_en;
  logic [4:0]  rf_w_addr;
  logic [31:0] rf_w_data;
  logic [4:0]  ra_addr, rb_addr, rc_addr;

  logic [31:0] ra_b, rb_b, rc_b;
  logic        rdy_b;
  logic [31:0] ra_n, rb_n, rc_n;
  logic        rdy_n;
  logic [31:0] ra_x, rb_x, rc_x;
  logic        rdy_x;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  beta_regfile #(.BYPASS(1'b1), .CLEAR_ON_RESET(1'b1)) u_byp (
    .clk(clk), .rst_n(rst_n), .rf_w_en(rf_w_en), .rf_w_addr(rf_w_addr),
    .rf_w_data(rf_w_data), .ra_addr(ra_addr), .ra_data(ra_b), .rb_addr(rb_addr),
    .rb_data(rb_b), .rc_addr(rc_addr), .rc_data(rc_b), .rf_ready(rdy_b)
  );

  beta_regfile #(.BYPASS(1'b0), .CLEAR_ON_RESET(1'b1)) u_nobyp (
    .clk(clk), .rst_n(rst_n), .rf_w_en(rf_w_en), .rf_w_addr(rf_w_addr),
    .rf_w_data(rf_w_data), .ra_addr(ra_addr), .ra_data(ra_n), .rb_addr(rb_addr),
    .rb_data(rb_n), .rc_addr(rc_addr), .rc_data(rc_n), .rf_ready(rdy_n)
  );

  beta_regfile #(.BYPASS(1'b1), .CLEAR_ON_RESET(1'b0)) u_noclr (
    .clk(clk), .rst_n(rst_n), .rf_w_en(rf_w_en), .rf_w_addr(rf_w_addr),
    .rf_w_data(rf_w_data), .ra_addr(ra_addr), .ra_data(ra_x), .rb_addr(rb_addr),
    .rb_data(rb_x), .rc_addr(rc_addr), .rc_data(rc_x), .rf_ready(rdy_x)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [4:0] a);
    ra_addr = a;
    rb_addr = a;
    rc_addr = a;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    rf_w_en   = 1'b1;
    rf_w_addr = a;
    rf_w_data = d;
    tick();
    rf_w_en   = 1'b0;
  endtask

  // Release reset and step through the 31-edge clear, checking rf_ready timing.
  task automatic clear_sequence(input string tag, input bit poke_r3);
    rst_n = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      tick();
      if (poke_r3 && i == 9) begin
        rf_w_en   = 1'b1;
        rf_w_addr = 5'd3;
        rf_w_data = 32'h55;
      end
      if (i == 10) rf_w_en = 1'b0;
      #1;
      if (i == 1) begin
        check({tag, "_noclr_ready_e1"}, {31'd0, rdy_x}, 32'd1);
        check({tag, "_ready_e1"}, {31'd0, rdy_b}, 32'd0);
        check({tag, "_clear_read"}, ra_b, 32'd0);
      end
      if (i == 30) check({tag, "_ready_e30"}, {31'd0, rdy_b}, 32'd0);
      if (i == 31) begin
        check({tag, "_ready_e31"}, {31'd0, rdy_b}, 32'd1);
        check({tag, "_ready_e31_nb"}, {31'd0, rdy_n}, 32'd1);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    rf_w_en   = 1'b0;
    rf_w_addr = '0;
    rf_w_data = '0;
    set_rd(5'd5);
    tick();
    tick();
    #1;
    check("rst_ready", {31'd0, rdy_b}, 32'd0);
    check("rst_ready_noclr", {31'd0, rdy_x}, 32'd0);
    check("rst_ra", ra_b, 32'd0);
    check("rst_rb", rb_n, 32'd0);
    check("rst_rc", rc_b, 32'd0);

    // Initial clear, with a write attempt to R3 during clear cycle 10.
    clear_sequence("init", 1'b1);

    for (int a = 0; a <= 30; a++) begin
      set_rd(a[4:0]);
      #1;
      check("clr_zero_a", ra_b, 32'd0);
      check("clr_zero_c", rc_n, 32'd0);
    end
    set_rd(5'd3);
    #1;
    check("r3_dropped", rb_b, 32'd0);

    // Write then read on all three ports.
    set_rd(5'd5);
    write(5'd5, 32'hDEADBEEF);
    #1;
    check("r5_ra", ra_b, 32'hDEADBEEF);
    check("r5_rb", rb_b, 32'hDEADBEEF);
    check("r5_rc", rc_b, 32'hDEADBEEF);
    check("r5_rc_nb", rc_n, 32'hDEADBEEF);

    // Same-cycle write/read of R7: bypass returns new, no-bypass returns old.
    set_rd(5'd0);
    write(5'd7, 32'h1);
    ra_addr   = 5'd7;
    rb_addr   = 5'd5;
    rf_w_en   = 1'b1;
    rf_w_addr = 5'd7;
    rf_w_data = 32'h2;
    #1;
    check("byp_new", ra_b, 32'h2);
    check("nobyp_old", ra_n, 32'h1);
    check("byp_other_port", rb_b, 32'hDEADBEEF);
    tick();
    rf_w_en = 1'b0;
    #1;
    check("r7_after_b", ra_b, 32'h2);
    check("r7_after_nb", ra_n, 32'h2);

    // R31: writes ignored, reads zero even while bypassing.
    rb_addr   = 5'd31;
    ra_addr   = 5'd30;
    rf_w_en   = 1'b1;
    rf_w_addr = 5'd31;
    rf_w_data = 32'hFFFFFFFF;
    #1;
    check("r31_same_cycle", rb_b, 32'd0);
    check("r31_same_cycle_nb", rb_n, 32'd0);
    tick();
    rf_w_en = 1'b0;
    #1;
    check("r31_after", rb_b, 32'd0);
    check("r30_untouched", ra_b, 32'd0);

    // Mid-operation reset: rf_ready drops at the edge, then a full re-clear.
    set_rd(5'd9);
    write(5'd9, 32'hABCD);
    #1;
    check("r9_written", ra_b, 32'hABCD);
    rst_n = 1'b0;
    tick();
    #1;
    check("mid_rst_ready", {31'd0, rdy_b}, 32'd0);
    check("mid_rst_read", ra_b, 32'd0);
    clear_sequence("reclr", 1'b0);
    #1;
    check("r9_recleared", ra_b, 32'd0);
    check("r9_recleared_nb", rc_n, 32'd0);
    ra_addr = 5'd5;
    #1;
    check("r5_recleared", ra_b, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
